// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots the counter value on each rising edge of
// cap into a small show-ahead FIFO. The oldest snapshot is presented on a
// valid/ready port. A capture that finds the FIFO full, with no pop in the
// same cycle, is dropped and recorded in a sticky overflow flag.
module count_capture_fifo #(
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [0:N]               count,
    input  logic                     cap,
    output logic [0:N]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [0:N]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          cap_d_r;
    logic          ovf_r;

    logic          cap_evt_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    // Status is derived from the entry count only; the pointers are equal
    // both when the FIFO is empty and when it is full.
    assign full_s    = (level_r == LW'(DEPTH));
    assign empty_s   = (level_r == {LW{1'b0}});
    assign cap_evt_s = cap & ~cap_d_r;
    assign pop_s     = ~empty_s & out_ready;
    // A pop in the same cycle frees a slot, so a capture into a full FIFO
    // is still accepted then.
    assign push_s    = cap_evt_s & (~full_s | pop_s);
    assign drop_s    = cap_evt_s & full_s & ~pop_s;

    // Next entry count from the push/pop combination of this cycle.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Capture-request history for rising-edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cap_d_r <= 1'b0;
        end else begin
            cap_d_r <= cap;
        end
    end

    // Storage array; reset clears every entry so the head reads zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(N+1){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= count;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers and entry count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_nxt_s;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = ~empty_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign level     = level_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed testbench for count_capture_fifo (N=3, DEPTH=4).
module tb_count_capture_fifo;

    logic       clk;
    logic       clr;
    logic [0:3] count;
    logic       cap;
    logic [0:3] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr;

    int total;
    int passed;

    count_capture_fifo #(.N(3), .DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .count     (count),
        .cap       (cap),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Apply inputs, advance one rising edge, settle 1 unit past it.
    task automatic cyc(input logic c, input logic rdy, input logic oc, input logic [3:0] cv);
        cap       = c;
        out_ready = rdy;
        ovf_clr   = oc;
        count     = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        clr       = 1'b0;
        cap       = 1'b1;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        count     = 4'd9;

        // Reset with busy inputs
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 1'b1, 4'd3);
        cyc(1'b1, 1'b0, 1'b0, 4'd12);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);

        // Release with cap low
        cap = 1'b0;
        clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd4);
        chk("idle_level", 32'(level), 32'd0);

        // Single capture at count 5
        cyc(1'b1, 1'b0, 1'b0, 4'd5);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data), 32'd5);
        chk("single_level", 32'(level), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd6);
        chk("single_pop_empty", 32'(empty), 32'd1);
        chk("single_pop_level", 32'(level), 32'd0);

        // Fill with 2, 6, 10, 14, then drop 1
        cyc(1'b1, 1'b0, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 4'd3);
        cyc(1'b1, 1'b0, 1'b0, 4'd6);
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        cyc(1'b1, 1'b0, 1'b0, 4'd10);
        chk("fill3_full", 32'(full), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        cyc(1'b1, 1'b0, 1'b0, 4'd14);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_ovf0",  32'(ovf), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd15);
        cyc(1'b1, 1'b0, 1'b0, 4'd1);
        chk("drop_ovf",   32'(ovf), 32'd1);
        chk("drop_level", 32'(level), 32'd4);
        chk("drop_head",  32'(out_data), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 4'd2);

        // Full with simultaneous push (9) and pop (2)
        cyc(1'b1, 1'b1, 1'b0, 4'd9);
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_full",  32'(full), 32'd1);
        chk("pp_ovf",   32'(ovf), 32'd1);
        chk("pp_head",  32'(out_data), 32'd6);

        // Drain: 10, 14, 9, then empty; the dropped 1 never appears
        cyc(1'b0, 1'b1, 1'b0, 4'd10);
        chk("drain_10", 32'(out_data), 32'd10);
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        chk("drain_14", 32'(out_data), 32'd14);
        cyc(1'b0, 1'b1, 1'b0, 4'd12);
        chk("drain_9",  32'(out_data), 32'd9);
        chk("drain_9_level", 32'(level), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd13);
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd14);
        chk("ready_while_empty", 32'(level), 32'd0);
        chk("drain_ovf_sticky", 32'(ovf), 32'd1);

        // cap held high for 5 cycles -> exactly one entry (3)
        cyc(1'b1, 1'b0, 1'b0, 4'd3);
        cyc(1'b1, 1'b0, 1'b0, 4'd4);
        cyc(1'b1, 1'b0, 1'b0, 4'd5);
        cyc(1'b1, 1'b0, 1'b0, 4'd6);
        cyc(1'b1, 1'b0, 1'b0, 4'd7);
        chk("held_level", 32'(level), 32'd1);
        chk("held_data",  32'(out_data), 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 4'd8);

        // Fill with 8, 10, 12
        cyc(1'b1, 1'b0, 1'b0, 4'd8);
        cyc(1'b0, 1'b0, 1'b0, 4'd9);
        cyc(1'b1, 1'b0, 1'b0, 4'd10);
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        cyc(1'b1, 1'b0, 1'b0, 4'd12);
        chk("refill_level", 32'(level), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 4'd13);

        // Drop together with ovf_clr: set wins
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        chk("setwins_ovf",   32'(ovf), 32'd1);
        chk("setwins_level", 32'(level), 32'd4);
        // ovf_clr alone clears
        cyc(1'b0, 1'b0, 1'b1, 4'd1);
        chk("ovfclr_ovf", 32'(ovf), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd2);

        // Pop one -> 3 entries (8, 10, 12)
        cyc(1'b0, 1'b1, 1'b0, 4'd3);
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_head",  32'(out_data), 32'd8);
        out_ready = 1'b0;

        // Asynchronous reset between edges
        #3;
        clr = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_data",  32'(out_data), 32'd0);

        // Hold cap high through release, capture count 7
        @(posedge clk); #1;
        cap   = 1'b1;
        count = 4'd7;
        #2;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data",  32'(out_data), 32'd7);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_ovf",   32'(ovf), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd8);
        chk("post_rst_held_level", 32'(level), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Timestamp capture buffer that sits directly downstream of the free-running `counter` block. On each rising edge of a capture request it snapshots the counter's `count` value into a small FIFO. It presents the oldest snapshot on a valid/ready output port. Captures that arrive while the FIFO is full are dropped and flagged, so a slow consumer can read event times without losing ordering.

## Interface
- `N`, 3, MSB index of the count bus; data width is N+1 (matches `counter`).
- `DEPTH`, 4, number of FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `count`  in  [0:N]  count value from `counter`; copied bit-for-bit, ordering unchanged.
- `cap`  in  1  capture request level, synchronous to `clk`; only rising edges capture.
- `out_data`  out  [0:N]  oldest stored snapshot (head); meaningful only when `out_valid`=1.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  current number of entries, 0..DEPTH.
- `ovf`  out  1  sticky flag: at least one capture was dropped.
- `ovf_clr`  in  1  synchronous clear for `ovf`.

## Operation
- **Edge detect:** register `cap_d` <= `cap` every cycle. Capture event `cap_evt` = `cap` & ~`cap_d`, evaluated at the rising edge of `clk`.
- **Push:** on `cap_evt`, if not `full` or a pop occurs in the same cycle:
  - write `count` (value sampled at that edge) to `mem[wr_ptr]`;
  - advance `wr_ptr` modulo DEPTH.
- **Drop:** on `cap_evt` with `full`=1 and no pop, nothing is written and `ovf` <= 1.
- **Pop:** `out_valid` & `out_ready` at the edge; advance `rd_ptr` modulo DEPTH.
  - `out_ready` while empty is ignored.
- **Head output:** `out_data` = `mem[rd_ptr]`, a combinational read (show-ahead).
- **Level update:**
  - push only: +1;
  - pop only: −1;
  - push and pop in the same cycle: unchanged.
- **Pointer wrap:** `wr_ptr`/`rd_ptr` wrap DEPTH−1 -> 0. `full`/`empty` are derived from `level`, never from pointer equality alone.
- **Overflow flag:** `ovf_clr` clears `ovf`. If a drop occurs in the same cycle as `ovf_clr`, set wins and `ovf` stays 1.
- **Count wrap:** `count` wrap-around (e.g. 15 -> 0 for N=3) needs no special handling; values are stored raw.

## Timing
- **Reset (`clr`=0, asynchronous):**
  - `wr_ptr`=`rd_ptr`=0, `level`=0, `cap_d`=0, `ovf`=0;
  - all `mem` entries = 0;
  - `out_data`=0, `out_valid`=0, `empty`=1, `full`=0.
- **Reset mid-operation:** all stored entries are discarded immediately; no partial push or pop completes.
- **Capture while `cap` is high at reset release:** `cap` held high through release produces exactly one capture at the first rising edge after release, because `cap_d` resets to 0.
- **Capture latency:** `cap` rises and is sampled high at edge k. The snapshot is `count` at edge k. If the FIFO was empty, `out_valid`=1 and `out_data` shows it from edge k onward (visible in cycle k+1).
- **No bypass:** a push into an empty FIFO is not visible on `out_data` in the same cycle.
- **Full with simultaneous push and pop:** the push is accepted, not dropped, and `level` stays at DEPTH.
- **Throughput:** one push and one pop per cycle maximum. A `cap` held high produces a single capture; it must go low for at least one cycle to re-arm.
- **Flag timing:** `full`, `empty`, `level` and `ovf` are registered or derived from registered state. They update one edge after the causing event.

## Test plan
- **Reset values:** hold `clr`=0 with random `cap`/`out_ready`/`count` -> `out_valid`=0, `empty`=1, `level`=0, `ovf`=0, `out_data`=0.
- **Single capture:**
  - stimulus: counter free-running 0..15; one-cycle `cap` pulse when `count`=5; `out_ready`=0;
  - response: next cycle `out_valid`=1, `out_data`=5, `level`=1;
  - then raise `out_ready` for one cycle -> `empty`=1.
- **Fill and overflow (DEPTH=4):**
  - stimulus: capture at counts 2, 6, 10, 14, then 1; `out_ready`=0;
  - response: `full`=1 after the fourth capture, fifth is dropped, `ovf`=1, `level`=4;
  - drain -> outputs 2, 6, 10, 14 in order; the wrapped 1 never appears.
- **Full with simultaneous push/pop:**
  - stimulus: at `full`=1, pulse `cap` at count 9 while `out_ready`=1;
  - response: `ovf` unchanged, `level` stays 4, 9 emerges last after draining.
- **Held cap and ovf set priority:**
  - `cap` held high 5 cycles -> exactly one entry;
  - `ovf_clr`=1 in the same cycle as a drop -> `ovf` stays 1;
  - `ovf_clr` alone -> `ovf`=0 next cycle.
- **Reset mid-stream:**
  - stimulus: 3 entries stored; assert `clr`=0 between clock edges;
  - response: `out_valid` drops immediately and `level`=0;
  - after release, a capture at count 7 yields `out_data`=7 as the first output.
